sparse_chunk_rx: RTL
====================

# sparse_chunk_rx

Synthesizable receiver for the sparse-chunk write stream the memory generator drives toward the IFM and filter SRAMs: sparsemap plus packed nonzero bytes, one bus beat per cycle, addressed by beat count and chunk count, with no back-pressure. It stores each beat into chunk storage, checks beat/chunk ordering, and counts nonzeros per chunk. It exposes a registered read port sized to the prefix-sum segment so compute units can fetch sparsemap and data slices. One instance sits per SRAM type: one for IFM, one for filter.

## Interface
- MEM_SIZE, 128: bytes per chunk (sparsemap bits per chunk).
- BUS_SIZE, 32: bytes per write beat; MEM_SIZE % BUS_SIZE == 0 is required.
- CHUNK_NUM, 4: chunks stored.
- PREFIX_SUM_SIZE, 32: read segment width in sparsemap bits; MEM_SIZE % PREFIX_SUM_SIZE == 0 is required.
- Derived: BEATS = MEM_SIZE/BUS_SIZE, SEGS = MEM_SIZE/PREFIX_SUM_SIZE.

Ports:
- clk_i  in  1  clock, all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  start a new load: FSM to IDLE, loaded flags and error cleared; storage untouched.
- wr_valid_i  in  1  beat present.
- wr_dat_count_i  in  clog2(BEATS)  beat index within chunk.
- wr_chunk_count_i  in  clog2(CHUNK_NUM)  chunk index.
- wr_sparsemap_i  in  BUS_SIZE  sparsemap slice.
- wr_nonzero_data_i  in  BUS_SIZE*8  nonzero byte slice.
- rd_en_i  in  1  read request.
- rd_chunk_i  in  clog2(CHUNK_NUM)  chunk to read.
- rd_seg_i  in  clog2(SEGS)  segment within chunk.
- rd_valid_o  out  1  read data valid, chunk was loaded.
- rd_miss_o  out  1  read hit an unloaded chunk.
- rd_sparsemap_o  out  PREFIX_SUM_SIZE  sparsemap segment.
- rd_nonzero_data_o  out  PREFIX_SUM_SIZE*8  nonzero byte segment (same slot indexing).
- rd_nz_count_o  out  clog2(MEM_SIZE+1)  total nonzeros of rd_chunk_i.
- chunk_loaded_o  out  CHUNK_NUM  per-chunk loaded flags.
- load_done_o  out  1  all chunks received in order.
- proto_err_o  out  1  sticky ordering error.

## Operation
- FSM states: IDLE, LOAD, DONE. Reset → IDLE.
- Every beat with wr_valid_i=1 is written unconditionally at storage slot [chunk][BUS_SIZE*dat_count +: BUS_SIZE] for both sparsemap and data. No ready signal exists.
- Expected counters exp_dat and exp_chunk start at 0. When a beat's (dat, chunk) differs from (exp_dat, exp_chunk), proto_err_o is set (sticky until rst_i or clear_i). Expected counters always advance from the *received* indices (resynchronize).
- IDLE: the first valid beat → LOAD.
- LOAD: beat with dat=BEATS-1 sets chunk_loaded_o[chunk]. When that beat also has chunk=CHUNK_NUM-1 → DONE.
- DONE: load_done_o=1. Any further beat is written, flags proto_err_o, and the state stays DONE.
- Gaps (wr_valid_i low mid-chunk) are legal; counters hold.
- nz counter per chunk: the dat=0 beat loads popcount(sparsemap); later beats add popcount. Width clog2(MEM_SIZE+1), no overflow possible.
- A write beat to a chunk whose loaded flag is set clears that flag until its last beat.
- clear_i and wr_valid_i in the same cycle: clear wins for flags and FSM, and the beat is still written and treated as the first beat of IDLE→LOAD.
- rst_i mid-stream: all flags, counters, and FSM clear; storage contents are undefined afterward.

## Timing
- Reset values: all outputs 0; rd_* data 0.
- Write-to-flag latency: chunk_loaded_o rises the cycle after the last beat. load_done_o rises in the same cycle.
- Read latency is 1 cycle: rd_en_i at cycle N gives rd_valid_o or rd_miss_o at N+1. The two are mutually exclusive and pulse for one cycle per request.
- Reads are read-before-write: a read and write to the same slot in the same cycle return the old data. The loaded check uses the flags as of cycle N.
- rd_nz_count_o is sampled alongside the data.

## Structure
- Package sparse_rx_pkg: the state enum, parameter-derived widths (BEATS, SEGS, count widths), and a static assert function for the divisibility checks.
- Sub-module popcount_bus: combinational popcount of BUS_SIZE bits, instantiated once.
- Storage is a flat register array; no SRAM macro is used.

## Test plan
- In-order full load (4 chunks × 4 beats, contiguous): load_done_o at cycle 17 after the first beat; chunk_loaded_o=4'hF; proto_err_o=0.
- Sparsemap beats 32'hFFFF_FFFF, 0, 32'h0000_000F, 1 into chunk 2: rd_nz_count_o=37. Reading seg 2 returns sparsemap 32'h0000_000F plus the matching bytes.
- Beat order 0,2,1,3 in chunk 0: proto_err_o rises the cycle after the dat=2 beat; data still lands correctly and readback matches.
- Read of chunk 3 while only chunks 0–2 are loaded: rd_miss_o=1 and rd_valid_o=0 one cycle later.
- Gaps of 3 idle cycles between every beat: same final state as a contiguous load, no error.
- rst_i asserted after chunk 1 beat 2, then a fresh load: flags cleared the next cycle; the new load completes with proto_err_o=0.

Source files
------------

// File: rtl/sparse_chunk_rx_pkg.sv
// sparse_rx_pkg: state type, default sizing, derived widths and
// sizing sanity helpers shared by the sparse-chunk receiver.
package sparse_rx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
  } state_t;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic bit div_ok(input int a, input int b);
    return (b > 0) && ((a % b) == 0);
  endfunction

  localparam int DEF_MEM_SIZE  = 128;
  localparam int DEF_BUS_SIZE  = 32;
  localparam int DEF_CHUNK_NUM = 4;
  localparam int DEF_PSUM_SIZE = 32;

  localparam int DEF_BEATS = DEF_MEM_SIZE / DEF_BUS_SIZE;
  localparam int DEF_SEGS  = DEF_MEM_SIZE / DEF_PSUM_SIZE;
  localparam int DEF_DAT_W = cw(DEF_BEATS);
  localparam int DEF_CHK_W = cw(DEF_CHUNK_NUM);
  localparam int DEF_SEG_W = cw(DEF_SEGS);
  localparam int DEF_NZ_W  = $clog2(DEF_MEM_SIZE + 1);

endpackage

// File: rtl/sparse_chunk_rx_popcount.sv
// popcount_bus: combinational population count of one bus-wide
// sparsemap slice. Ports: bits (slice in), count (ones out).
module popcount_bus #(
  parameter int W = 32
) (
  input  logic [W-1:0]           bits,
  output logic [$clog2(W+1)-1:0] count
);

  localparam int CW = $clog2(W + 1);

  always_comb begin
    count = '0;
    for (int i = 0; i < W; i++) begin
      count = count + CW'(bits[i]);
    end
  end

endmodule

// File: rtl/sparse_chunk_rx.sv
// sparse_chunk_rx: stores sparsemap/nonzero write beats per chunk,
// checks beat/chunk order, counts nonzeros, serves registered reads.
// Ports: clk_i/rst_i/clear_i, wr_* beat stream, rd_* segment read,
// chunk_loaded_o, load_done_o, proto_err_o status.
module sparse_chunk_rx
  import sparse_rx_pkg::*;
#(
  parameter int MEM_SIZE        = DEF_MEM_SIZE,
  parameter int BUS_SIZE        = DEF_BUS_SIZE,
  parameter int CHUNK_NUM       = DEF_CHUNK_NUM,
  parameter int PREFIX_SUM_SIZE = DEF_PSUM_SIZE
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic                                   clear_i,
  input  logic                                   wr_valid_i,
  input  logic [cw(MEM_SIZE/BUS_SIZE)-1:0]       wr_dat_count_i,
  input  logic [cw(CHUNK_NUM)-1:0]               wr_chunk_count_i,
  input  logic [BUS_SIZE-1:0]                    wr_sparsemap_i,
  input  logic [BUS_SIZE*8-1:0]                  wr_nonzero_data_i,
  input  logic                                   rd_en_i,
  input  logic [cw(CHUNK_NUM)-1:0]               rd_chunk_i,
  input  logic [cw(MEM_SIZE/PREFIX_SUM_SIZE)-1:0] rd_seg_i,
  output logic                                   rd_valid_o,
  output logic                                   rd_miss_o,
  output logic [PREFIX_SUM_SIZE-1:0]             rd_sparsemap_o,
  output logic [PREFIX_SUM_SIZE*8-1:0]           rd_nonzero_data_o,
  output logic [$clog2(MEM_SIZE+1)-1:0]          rd_nz_count_o,
  output logic [CHUNK_NUM-1:0]                   chunk_loaded_o,
  output logic                                   load_done_o,
  output logic                                   proto_err_o
);

  localparam int NBEAT = MEM_SIZE / BUS_SIZE;
  localparam int DAT_W = cw(NBEAT);
  localparam int CHK_W = cw(CHUNK_NUM);
  localparam int NZ_W  = $clog2(MEM_SIZE + 1);
  localparam int PC_W  = $clog2(BUS_SIZE + 1);
  localparam int MW    = cw(MEM_SIZE);
  localparam int DW    = cw(MEM_SIZE * 8);
  localparam int PS    = PREFIX_SUM_SIZE;

  localparam logic [DAT_W-1:0] LAST_DAT = DAT_W'(NBEAT - 1);
  localparam logic [CHK_W-1:0] LAST_CHK = CHK_W'(CHUNK_NUM - 1);

  if (!div_ok(MEM_SIZE, BUS_SIZE) ||
      !div_ok(MEM_SIZE, PREFIX_SUM_SIZE)) begin : g_bad_size
    $error("sparse_chunk_rx: MEM_SIZE not divisible");
  end

  logic [MEM_SIZE-1:0]   smap_q [CHUNK_NUM];
  logic [MEM_SIZE*8-1:0] data_q [CHUNK_NUM];
  logic [NZ_W-1:0]       nz_q   [CHUNK_NUM];

  logic [MW-1:0] wr_sbase, rd_sbase;
  logic [DW-1:0] wr_dbase, rd_dbase;
  logic [PC_W-1:0] pc;

  assign wr_sbase = MW'(wr_dat_count_i) * MW'(BUS_SIZE);
  assign wr_dbase = DW'(wr_dat_count_i) * DW'(BUS_SIZE * 8);
  assign rd_sbase = MW'(rd_seg_i) * MW'(PS);
  assign rd_dbase = DW'(rd_seg_i) * DW'(PS * 8);

  popcount_bus #(.W(BUS_SIZE)) u_pc (
    .bits  (wr_sparsemap_i),
    .count (pc)
  );

  // Storage has no reset: every beat lands, whatever the FSM says.
  always_ff @(posedge clk_i) begin
    if (wr_valid_i) begin
      smap_q[wr_chunk_count_i][wr_sbase +: BUS_SIZE] <= wr_sparsemap_i;
      data_q[wr_chunk_count_i][wr_dbase +: BUS_SIZE*8] <= wr_nonzero_data_i;
    end
  end

  state_t           state_q;
  logic [DAT_W-1:0] exp_dat_q;
  logic [CHK_W-1:0] exp_chk_q;
  logic             mismatch;
  logic             last_beat;
  logic [CHK_W-1:0] c;

  assign c         = wr_chunk_count_i;
  assign last_beat = (wr_dat_count_i == LAST_DAT);
  assign mismatch  = (wr_dat_count_i != exp_dat_q) ||
                     (c != exp_chk_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      exp_dat_q         <= '0;
      exp_chk_q         <= '0;
      chunk_loaded_o    <= '0;
      load_done_o       <= 1'b0;
      proto_err_o       <= 1'b0;
      rd_valid_o        <= 1'b0;
      rd_miss_o         <= 1'b0;
      rd_sparsemap_o    <= '0;
      rd_nonzero_data_o <= '0;
      rd_nz_count_o     <= '0;
      for (int i = 0; i < CHUNK_NUM; i++) begin
        nz_q[i] <= '0;
      end
    end else begin
      // Flags as of this cycle; data is read before this cycle's write.
      rd_valid_o <= rd_en_i && chunk_loaded_o[rd_chunk_i];
      rd_miss_o  <= rd_en_i && !chunk_loaded_o[rd_chunk_i];
      if (rd_en_i) begin
        rd_sparsemap_o    <= smap_q[rd_chunk_i][rd_sbase +: PS];
        rd_nonzero_data_o <= data_q[rd_chunk_i][rd_dbase +: PS*8];
        rd_nz_count_o     <= nz_q[rd_chunk_i];
      end

      if (wr_valid_i) begin
        nz_q[c] <= (wr_dat_count_i == '0) ? NZ_W'(pc)
                                          : nz_q[c] + NZ_W'(pc);
        // Resynchronize to what actually arrived.
        exp_dat_q <= last_beat ? '0 : wr_dat_count_i + 1'b1;
        exp_chk_q <= !last_beat        ? c  :
                     (c == LAST_CHK)   ? '0 : c + 1'b1;
      end

      if (clear_i) begin
        chunk_loaded_o <= '0;
        load_done_o    <= 1'b0;
        proto_err_o    <= 1'b0;
        state_q        <= wr_valid_i ? LOAD : IDLE;
        if (!wr_valid_i) begin
          exp_dat_q <= '0;
          exp_chk_q <= '0;
        end
      end else if (wr_valid_i) begin
        chunk_loaded_o[c] <= last_beat;
        if (mismatch || state_q == DONE) begin
          proto_err_o <= 1'b1;
        end
        unique case (state_q)
          IDLE: state_q <= LOAD;
          LOAD: begin
            if (last_beat && c == LAST_CHK) begin
              state_q     <= DONE;
              load_done_o <= 1'b1;
            end
          end
          DONE: state_q <= DONE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule
